// File: rtl/phase_recover.sv
// Iterative vectoring-mode CORDIC: recovers the 16-bit phase word (2*pi = 0x10000)
// and the unscaled magnitude of a signed Q1.15 (cos, sin) pair.
module phase_recover #(
   parameter int ITERS = 14
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [15:0] g0,
   input  logic signed [15:0] g1,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [15:0]        phase,
   output logic [17:0]        mag
);

   typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_t;

   localparam logic [4:0] LAST = 5'(ITERS);

   state_t             state_q, state_d;
   logic signed [17:0] x_q, x_d, y_q, y_d, xs, ys, g0x, g1x;
   logic [15:0]        z_q, z_d, phase_q, phase_d;
   logic [17:0]        mag_q, mag_d;
   logic [4:0]         i_q, i_d;
   logic               in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic               zero_q, zero_d;

   function automatic logic [15:0] atan_lut(input logic [3:0] k);
      case (k)
         4'd0:    atan_lut = 16'd8192;
         4'd1:    atan_lut = 16'd4836;
         4'd2:    atan_lut = 16'd2555;
         4'd3:    atan_lut = 16'd1297;
         4'd4:    atan_lut = 16'd651;
         4'd5:    atan_lut = 16'd326;
         4'd6:    atan_lut = 16'd163;
         4'd7:    atan_lut = 16'd81;
         4'd8:    atan_lut = 16'd41;
         4'd9:    atan_lut = 16'd20;
         4'd10:   atan_lut = 16'd10;
         4'd11:   atan_lut = 16'd5;
         4'd12:   atan_lut = 16'd3;
         4'd13:   atan_lut = 16'd1;
         4'd14:   atan_lut = 16'd1;
         default: atan_lut = 16'd0;
      endcase
   endfunction

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      z_d         = z_q;
      i_d         = i_q;
      phase_d     = phase_q;
      mag_d       = mag_q;
      out_valid_d = out_valid_q;
      zero_d      = zero_q;
      g0x         = {{2{g0[15]}}, g0};
      g1x         = {{2{g1[15]}}, g1};
      xs          = x_q >>> i_q;
      ys          = y_q >>> i_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               // Fold the left half-plane onto the right so the rotations converge.
               if (g0[15]) begin
                  x_d = -g0x;
                  y_d = -g1x;
                  z_d = 16'h8000;
               end else begin
                  x_d = g0x;
                  y_d = g1x;
                  z_d = 16'h0000;
               end
               // The all-zero vector would otherwise accumulate every ATAN step.
               zero_d  = (g0 == 16'sd0) && (g1 == 16'sd0);
               i_d     = 5'd0;
               state_d = ITER;
            end
         end
         ITER: begin
            if (i_q < LAST) begin
               if (!y_q[17]) begin
                  x_d = x_q + ys;
                  y_d = y_q - xs;
                  z_d = z_q + atan_lut(i_q[3:0]);
               end else begin
                  x_d = x_q - ys;
                  y_d = y_q + xs;
                  z_d = z_q - atan_lut(i_q[3:0]);
               end
               i_d = i_q + 5'd1;
            end else begin
               // Extra output-register cycle: result appears ITERS+1 edges after accept.
               phase_d     = zero_q ? 16'h0000 : z_q;
               mag_d       = $unsigned(x_q);
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         i_q         <= '0;
         phase_q     <= '0;
         mag_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         i_q         <= i_d;
         phase_q     <= phase_d;
         mag_q       <= mag_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         zero_q      <= zero_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign phase     = phase_q;
   assign mag       = mag_q;

endmodule

// File: tb/tb_phase_recover.sv
// Directed bench for phase_recover: quadrants, extremes, backpressure, reset abort, round trip.
module tb_phase_recover;

   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [15:0] g0 = '0, g1 = '0;
   logic        in_ready, out_valid;
   logic [15:0] phase;
   logic [17:0] mag;
   int          nchk = 0, nerr = 0;

   always #5 clk = ~clk;

   phase_recover #(.ITERS(14)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .g0(g0), .g1(g1), .out_valid(out_valid), .out_ready(out_ready),
      .phase(phase), .mag(mag)
   );

   task automatic chk(input string tag, input int got, input int exp, input int tol, input bit wrap);
      int d;
      logic signed [15:0] d16;
      nchk++;
      d = got - exp;
      if (wrap) begin
         d16 = d[15:0];
         d   = int'(d16);
      end
      if (d < 0) d = -d;
      if (d > tol) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
      end
   endtask

   task automatic send(input logic [15:0] a, input logic [15:0] b, output int lat);
      int n;
      @(negedge clk);
      g0 = a; g1 = b; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      chk("accept_ready", int'(in_ready), 1, 0, 0);
      @(posedge clk); #1;
      in_valid = 1'b0; g0 = 16'h5A5A; g1 = 16'hA5A5;
      lat = 0;
      while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
   endtask

   task automatic take();
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      chk("ov_drop", int'(out_valid), 0, 0, 0);
      chk("ir_back", int'(in_ready), 1, 0, 0);
   endtask

   task automatic xact(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input int ep, input int ptol, input int em, input int mtol);
      int lat;
      send(a, b, lat);
      chk({tag, "_lat"}, lat, 15, 0, 0);
      chk({tag, "_phase"}, int'(phase), ep, ptol, 1);
      if (mtol >= 0) chk({tag, "_mag"}, int'(mag), em, mtol, 0);
      take();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int  lat, n, a, b;
      real ang, c, s;

      // Reset state
      #12;
      chk("rst_in_ready", int'(in_ready), 0, 0, 0);
      chk("rst_out_valid", int'(out_valid), 0, 0, 0);
      chk("rst_phase", int'(phase), 0, 0, 0);
      chk("rst_mag", int'(mag), 0, 0, 0);
      @(negedge clk); rst_n = 1'b1;
      chk("rel_in_ready_lo", int'(in_ready), 0, 0, 0);
      @(posedge clk); #1;
      chk("rel_in_ready_hi", int'(in_ready), 1, 0, 0);

      // Axes, extreme corner and zero vector
      xact("px",   16'd32767, 16'd0,     16'h0000, 4, 53958, 8);
      xact("py",   16'd0,     16'd32767, 16'h4000, 4, 0,     -1);
      xact("nx",   16'h8001,  16'd0,     16'h8000, 4, 0,     -1);
      xact("ny",   16'd0,     16'h8001,  16'hC000, 4, 0,     -1);
      xact("min",  16'h8000,  16'h8000,  16'hA000, 4, 76312, 8);
      xact("zero", 16'd0,     16'd0,     16'h0000, 0, 0,     0);

      // Backpressure: result held, in_ready low, extra in_valid ignored
      send(16'd0, 16'd32767, lat);
      chk("bp_lat", lat, 15, 0, 0);
      repeat (10) begin
         @(negedge clk); in_valid = 1'b1; g0 = 16'd32767; g1 = 16'd0;
         @(posedge clk); #1;
         chk("bp_phase", int'(phase), 16'h4000, 4, 1);
         chk("bp_ov", int'(out_valid), 1, 0, 0);
         chk("bp_ir", int'(in_ready), 0, 0, 0);
      end
      in_valid = 1'b0;
      take();

      // in_valid pulsed mid-iteration must not disturb the transaction
      @(negedge clk); g0 = 16'd0; g1 = 16'h8001; in_valid = 1'b1;
      chk("it_ir_pre", int'(in_ready), 1, 0, 0);
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (4) @(negedge clk);
      g0 = 16'd32767; g1 = 16'd0; in_valid = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      chk("it_ir", int'(in_ready), 0, 0, 0);
      n = 0;
      while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
      chk("it_phase", int'(phase), 16'hC000, 4, 1);
      take();
      repeat (3) @(posedge clk);
      #1 chk("it_no_second", int'(out_valid), 0, 0, 0);

      // Reset mid-operation at i=5
      @(negedge clk); g0 = 16'd32767; g1 = 16'd0; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_ov", int'(out_valid), 0, 0, 0);
      chk("mid_rst_ir", int'(in_ready), 0, 0, 0);
      chk("mid_rst_phase", int'(phase), 0, 0, 0);
      @(negedge clk); rst_n = 1'b1;
      chk("mid_rel_ir_lo", int'(in_ready), 0, 0, 0);
      @(posedge clk); #1;
      chk("mid_rel_ir_hi", int'(in_ready), 1, 0, 0);
      chk("mid_rel_ov", int'(out_valid), 0, 0, 0);
      xact("post_rst", 16'd0, 16'd32767, 16'h4000, 4, 0, -1);

      // Round trip against an ideal sin/cos source
      for (int u = 0; u < 65536; u += 257) begin
         ang = 2.0 * 3.141592653589793 * real'(u) / 65536.0;
         c = 32767.0 * $cos(ang);
         s = 32767.0 * $sin(ang);
         a = $rtoi(c >= 0.0 ? c + 0.5 : c - 0.5);
         b = $rtoi(s >= 0.0 ? s + 0.5 : s - 0.5);
         send(16'(a), 16'(b), lat);
         chk($sformatf("rt_lat_%0d", u), lat, 15, 0, 0);
         chk($sformatf("rt_phase_%0d", u), int'(phase), u, 16, 1);
         take();
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
